mrd_frame_sched: RTL and testbench

//  Frame-level scheduler for the mixed-radix 2/3/4/5 DFT engine. It drives the bank-select `sw` of the
//  mem0/mem1 <-> rdx2345 switch and runs each accepted frame through all its radix stages in place.

---
 rtl/mrd_pkg.sv | 20 ++
 rtl/mrd_grp_cnt.sv | 43 ++++
 rtl/mrd_frame_sched.sv | 212 +++++++++++++++++++++
 tb/tb_mrd_frame_sched.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mrd_pkg.sv
// rtl/mrd_pkg.sv - shared state type, radix limits and factor check for the mixed-radix frame scheduler
package mrd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK,
    ISSUE,
    DRAIN,
    GAP
  } sched_state_e;

  localparam logic [2:0] FACTOR_MIN = 3'd2;
  localparam logic [2:0] FACTOR_MAX = 3'd5;

  // A stage radix is usable only if the butterfly engine implements it
  function automatic logic factor_ok(input logic [2:0] f);
    return (f >= FACTOR_MIN) && (f <= FACTOR_MAX);
  endfunction

endpackage

// File: rtl/mrd_grp_cnt.sv
// rtl/mrd_grp_cnt.sv - per-stage issued-group and writeback counters with balance/overflow flags
module mrd_grp_cnt #(
  parameter int CNT_W = 13
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic count_en,
  input  logic grant,
  input  logic wb,
  output logic balanced,
  output logic overflow
);

  logic [CNT_W-1:0] issued;
  logic [CNT_W-1:0] wb_cnt;
  logic [CNT_W-1:0] issued_nxt;
  logic [CNT_W-1:0] wb_nxt;

  // Next-count values so a writeback landing with a grant is judged against both
  always_comb begin
    issued_nxt = issued + CNT_W'(grant);
    wb_nxt     = wb_cnt + CNT_W'(wb);
  end

  assign balanced = (wb_cnt == issued);
  assign overflow = count_en && wb && (wb_nxt > issued_nxt);

  // Clear at stage start; a writeback in the clearing cycle still counts
  always_ff @(posedge clk) begin
    if (rst) begin
      issued <= '0;
      wb_cnt <= '0;
    end else if (clr) begin
      issued <= '0;
      wb_cnt <= CNT_W'(count_en && wb);
    end else if (count_en) begin
      issued <= issued_nxt;
      wb_cnt <= wb_nxt;
    end
  end

endmodule

// File: rtl/mrd_frame_sched.sv
// rtl/mrd_frame_sched.sv - frame/stage scheduler for the radix-2/3/4/5 DFT engine; optional watchdog: MRD_SCHED_WDOG_EN
module mrd_frame_sched
  import mrd_pkg::*;
#(
  parameter int MAX_STG  = 8,
  parameter int LEN_W    = 12,
  parameter int GAP_CYC  = 4,
  parameter int WDOG_CYC = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frm_valid,
  output logic                       frm_ready,
  input  logic [LEN_W-1:0]           cfg_len,
  input  logic [3:0]                 cfg_nstg,
  input  logic [3*MAX_STG-1:0]       cfg_factors,
  output logic                       sw,
  output logic [$clog2(MAX_STG)-1:0] stage_idx,
  output logic [2:0]                 factor,
  output logic                       grp_valid,
  input  logic                       grp_ready,
  output logic [LEN_W-1:0]           grp_addr,
  input  logic                       wb_valid,
  output logic                       frm_done,
  output logic                       busy,
  output logic                       err
);

  localparam int STG_W = $clog2(MAX_STG);
  localparam int GAP_W = $clog2(GAP_CYC + 1);

  if (GAP_CYC < 1 || WDOG_CYC < 1) begin : g_param_check
    $error("mrd_frame_sched: GAP_CYC and WDOG_CYC must be at least 1");
  end

  sched_state_e         state;
  logic                 sw_nxt;
  logic [LEN_W-1:0]     len_q;
  logic [3:0]           nstg_q;
  logic [3*MAX_STG-1:0] facs_q;
  logic [LEN_W:0]       acc;
  logic [GAP_W-1:0]     gap_cnt;

  logic [LEN_W:0]       acc_sum;
  logic                 last_grp;
  logic [STG_W-1:0]     stage_nxt;
  logic [2:0]           next_factor;
  logic                 last_stg;
  logic                 gap_done;
  logic                 cfg_bad;
  logic                 grant;
  logic                 count_en;
  logic                 cnt_clr;
  logic                 balanced;
  logic                 ovf;
  logic                 ovf_err;
  logic                 wb_err;
  logic                 wdog_hit;

  // Validate the latched frame configuration; only stages in use must carry a legal radix
  always_comb begin
    cfg_bad = (nstg_q == 4'd0) || (nstg_q > 4'(MAX_STG)) || (len_q == '0);
    for (int s = 0; s < MAX_STG; s++) begin
      if ((4'(s) < nstg_q) && !factor_ok(facs_q[3*s +: 3])) begin
        cfg_bad = 1'b1;
      end
    end
  end

  // Stage progress terms: point accumulator step, stage advance and gap timing
  always_comb begin
    acc_sum     = acc + (LEN_W+1)'(factor);
    last_grp    = (acc_sum >= {1'b0, len_q});
    stage_nxt   = stage_idx + STG_W'(1);
    next_factor = facs_q[3*int'(stage_nxt) +: 3];
    last_stg    = (4'(stage_idx) == (nstg_q - 4'd1));
    gap_done    = (gap_cnt == GAP_W'(GAP_CYC - 1));
  end

  assign grant    = grp_valid && grp_ready;
  assign count_en = (state == CHK) || (state == ISSUE) || (state == DRAIN);
  assign cnt_clr  = ((state == CHK) && !cfg_bad) ||
                    ((state == GAP) && gap_done && !last_stg);
  assign ovf_err  = ovf && ((state == ISSUE) || (state == DRAIN));
  assign wb_err   = wb_valid && ((state == IDLE) || (state == GAP));

  assign grp_addr  = acc[LEN_W-1:0];
  assign busy      = (state != IDLE);
  // Held low through the frm_done cycle so a new frame is taken one cycle later at the earliest
  assign frm_ready = (state == IDLE) && !err && !frm_done;

  mrd_grp_cnt #(
    .CNT_W(LEN_W + 1)
  ) u_grp_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .count_en (count_en),
    .grant    (grant),
    .wb       (wb_valid),
    .balanced (balanced),
    .overflow (ovf)
  );

`ifdef MRD_SCHED_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYC + 1);
  logic [WD_W-1:0] wdog_cnt;

  // Cycles spent in ISSUE/DRAIN without any group handshake or writeback
  always_ff @(posedge clk) begin
    if (rst || !((state == ISSUE) || (state == DRAIN)) || wb_valid || grant) begin
      wdog_cnt <= '0;
    end else if (!wdog_hit) begin
      wdog_cnt <= wdog_cnt + WD_W'(1);
    end
  end

  assign wdog_hit = ((state == ISSUE) || (state == DRAIN)) && (wdog_cnt == WD_W'(WDOG_CYC));
`else
  assign wdog_hit = 1'b0;
`endif

  // Frame FSM: accept, check, per-stage issue/drain/gap, then frame completion
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sw        <= 1'b0;
      sw_nxt    <= 1'b0;
      len_q     <= '0;
      nstg_q    <= '0;
      facs_q    <= '0;
      acc       <= '0;
      gap_cnt   <= '0;
      stage_idx <= '0;
      factor    <= '0;
      grp_valid <= 1'b0;
      frm_done  <= 1'b0;
      err       <= 1'b0;
    end else begin
      frm_done <= 1'b0;
      if (wb_err || ovf_err) begin
        err <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (frm_valid && frm_ready) begin
            len_q     <= cfg_len;
            nstg_q    <= cfg_nstg;
            facs_q    <= cfg_factors;
            sw        <= sw_nxt;
            sw_nxt    <= ~sw_nxt;
            stage_idx <= '0;
            state     <= CHK;
          end
        end
        CHK: begin
          if (cfg_bad) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            acc       <= '0;
            stage_idx <= '0;
            factor    <= facs_q[2:0];
            grp_valid <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (grp_ready) begin
            acc <= acc_sum;
            if (last_grp) begin
              grp_valid <= 1'b0;
              state     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (balanced) begin
            gap_cnt <= '0;
            state   <= GAP;
          end
        end
        GAP: begin
          if (gap_done) begin
            if (last_stg) begin
              frm_done <= 1'b1;
              state    <= IDLE;
            end else begin
              stage_idx <= stage_nxt;
              factor    <= next_factor;
              acc       <= '0;
              grp_valid <= 1'b1;
              state     <= ISSUE;
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          grp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
      if (wdog_hit) begin
        err       <= 1'b1;
        grp_valid <= 1'b0;
        state     <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_mrd_frame_sched.sv
// tb/tb_mrd_frame_sched.sv - randomized self-checking bench for mrd_frame_sched against a group-list model
module tb_mrd_frame_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frm_valid = 1'b0;
  logic        frm_ready;
  logic [11:0] cfg_len = '0;
  logic [3:0]  cfg_nstg = '0;
  logic [23:0] cfg_factors = '0;
  logic        sw;
  logic [2:0]  stage_idx;
  logic [2:0]  factor;
  logic        grp_valid;
  logic        grp_ready = 1'b1;
  logic [11:0] grp_addr;
  logic        wb_valid = 1'b0;
  logic        frm_done;
  logic        busy;
  logic        err;

  mrd_frame_sched #(
    .MAX_STG(8), .LEN_W(12), .GAP_CYC(4), .WDOG_CYC(16)
  ) dut (
    .clk(clk), .rst(rst), .frm_valid(frm_valid), .frm_ready(frm_ready),
    .cfg_len(cfg_len), .cfg_nstg(cfg_nstg), .cfg_factors(cfg_factors),
    .sw(sw), .stage_idx(stage_idx), .factor(factor), .grp_valid(grp_valid),
    .grp_ready(grp_ready), .grp_addr(grp_addr), .wb_valid(wb_valid),
    .frm_done(frm_done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {int stg; int fac; int addr; int bank;} grp_t;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  grp_t obs[$];
  grp_t expq[$];
  int   due[$];
  bit   rdy_rand = 0, hold_stg1 = 0, hold_all = 0, inject_wb = 0, wb_mute = 0;
  bit   stall_pending = 0;
  int   stall_addr = 0;
  int   wb_sent = 0;
  bit   next_sw = 0;
  grp_t rsp_g;
  int   rsp_d;

  // Read/writeback side: random grp_ready, group capture, delayed writebacks, stall-hold check
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (wb_mute) begin
        due.delete();
        wb_valid = 1'b0;
        grp_ready = 1'b1;
        stall_pending = 0;
        inject_wb = 0;
      end else begin
        if (stall_pending) begin
          vectors++;
          if (grp_valid !== 1'b1 || int'(grp_addr) != stall_addr) begin
            miscompares++;
            $display("FAIL grp_hold: valid=%b addr=%0d, required valid=1 addr=%0d", grp_valid, grp_addr, stall_addr);
          end
          stall_pending = 0;
        end
        grp_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (grp_valid === 1'b1 && grp_ready) begin
          rsp_g = '{stg: int'(stage_idx), fac: int'(factor), addr: int'(grp_addr), bank: int'(sw)};
          obs.push_back(rsp_g);
          if (!hold_all && !(hold_stg1 && stage_idx == 3'd1)) begin
            rsp_d = cyc + int'($urandom_range(1, 4));
            if (due.size() > 0 && rsp_d <= due[$]) rsp_d = due[$] + 1;
            due.push_back(rsp_d);
          end
        end else if (grp_valid === 1'b1) begin
          stall_pending = 1;
          stall_addr = int'(grp_addr);
        end
        wb_valid = 1'b0;
        if (inject_wb) begin
          wb_valid = 1'b1;
          inject_wb = 0;
        end else if (due.size() > 0 && due[0] <= cyc) begin
          void'(due.pop_front());
          wb_valid = 1'b1;
          wb_sent++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, required to have finished");
    $fatal(1);
  end

  task automatic do_reset();
    wb_mute = 1;
    rst = 1'b1;
    frm_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wb_mute = 0;
    next_sw = 0;
    wb_sent = 0;
  endtask

  task automatic test_reset(input string tag);
    do_reset();
    vectors++; if (frm_ready !== 1'b1) begin miscompares++; $display("FAIL %s frm_ready: got %b, required 1", tag, frm_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL %s busy: got %b, required 0", tag, busy); end
    vectors++; if (sw !== 1'b0) begin miscompares++; $display("FAIL %s sw: got %b, required 0", tag, sw); end
    vectors++; if (grp_valid !== 1'b0) begin miscompares++; $display("FAIL %s grp_valid: got %b, required 0", tag, grp_valid); end
    vectors++; if (frm_done !== 1'b0) begin miscompares++; $display("FAIL %s frm_done: got %b, required 0", tag, frm_done); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL %s err: got %b, required 0", tag, err); end
    vectors++; if (stage_idx !== 3'd0 || factor !== 3'd0 || grp_addr !== 12'd0) begin
      miscompares++; $display("FAIL %s stage/factor/addr: got %0d/%0d/%0d, required 0/0/0", tag, stage_idx, factor, grp_addr);
    end
  endtask

  task automatic start_frame(input string tag, input int len, input int nstg, input logic [23:0] facs, output bit bank);
    int n = 0;
    while (frm_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    vectors++;
    if (frm_ready !== 1'b1) begin miscompares++; $display("FAIL %s accept_ready: got %b, required 1", tag, frm_ready); end
    cfg_len = 12'(len);
    cfg_nstg = 4'(nstg);
    cfg_factors = facs;
    frm_valid = 1'b1;
    obs.delete();
    @(negedge clk);
    frm_valid = 1'b0;
    bank = next_sw;
    next_sw = ~next_sw;
  endtask

  task automatic run_frame(input string tag, input int len, input int nstg, input logic [23:0] facs);
    bit bank;
    int n = 0, bad_rdy = 0, bad_sw = 0, f, m;
    start_frame(tag, len, nstg, facs, bank);
    expq.delete();
    for (int s = 0; s < nstg; s++) begin
      f = int'(facs[3*s +: 3]);
      for (int a = 0; a < len; a += f) expq.push_back('{stg: s, fac: f, addr: a, bank: int'(bank)});
    end
    while (frm_done !== 1'b1 && n < 4000) begin
      if (frm_ready !== 1'b0 || busy !== 1'b1) bad_rdy++;
      if (sw !== bank) bad_sw++;
      @(negedge clk);
      n++;
    end
    vectors++; if (frm_done !== 1'b1) begin miscompares++; $display("FAIL %s frm_done: not seen in %0d cycles, required 1", tag, n); end
    vectors++; if (bad_rdy != 0 || frm_ready !== 1'b0) begin
      miscompares++; $display("FAIL %s ready_low: %0d busy cycles with frm_ready high or busy low, done-cycle ready=%b, required 0/0", tag, bad_rdy, frm_ready);
    end
    vectors++; if (bad_sw != 0 || sw !== bank) begin miscompares++; $display("FAIL %s sw_const: %0d cycles off, sw=%b, required %b", tag, bad_sw, sw, bank); end
    @(negedge clk);
    vectors++; if (frm_ready !== 1'b1) begin miscompares++; $display("FAIL %s ready_rise: got %b, required 1", tag, frm_ready); end
    vectors++; if (frm_done !== 1'b0) begin miscompares++; $display("FAIL %s done_pulse: got %b one cycle later, required 0", tag, frm_done); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL %s err: got %b, required 0", tag, err); end
    vectors++; if (obs.size() != expq.size()) begin miscompares++; $display("FAIL %s grp_count: got %0d, required %0d", tag, obs.size(), expq.size()); end
    m = (obs.size() < expq.size()) ? obs.size() : expq.size();
    for (int i = 0; i < m; i++) begin
      vectors++;
      if (obs[i].stg != expq[i].stg || obs[i].fac != expq[i].fac || obs[i].addr != expq[i].addr || obs[i].bank != expq[i].bank) begin
        miscompares++;
        $display("FAIL %s grp[%0d]: got stg=%0d fac=%0d addr=%0d sw=%0d, required stg=%0d fac=%0d addr=%0d sw=%0d", tag, i,
                 obs[i].stg, obs[i].fac, obs[i].addr, obs[i].bank, expq[i].stg, expq[i].fac, expq[i].addr, expq[i].bank);
      end
    end
  endtask

  task automatic rand_frame(input string tag);
    int len, nstg;
    logic [23:0] facs;
    len = int'($urandom_range(1, 40));
    nstg = int'($urandom_range(1, 3));
    for (int s = 0; s < 8; s++) facs[3*s +: 3] = (s < nstg) ? 3'($urandom_range(2, 5)) : 3'($urandom_range(0, 7));
    run_frame(tag, len, nstg, facs);
  endtask

  task automatic test_basic();
    run_frame("basic", 12, 2, 24'o43);
    run_frame("unused_fac", 10, 1, 24'o77777772);
    run_frame("len1", 1, 1, 24'o5);
  endtask

  task automatic test_back_to_back();
    test_reset("b2b_rst");
    run_frame("b2b0", 12, 2, 24'o43);
    for (int k = 0; k < 3; k++) rand_frame("b2b_rand");
  endtask

  task automatic test_grp_stall();
    rdy_rand = 1;
    run_frame("stall", 12, 2, 24'o43);
    rand_frame("stall_rand");
    rand_frame("stall_rand");
    rdy_rand = 0;
  endtask

  task automatic test_bad_cfg();
    int lens[5] = '{12, 12, 0, 12, 12};
    int nstgs[5] = '{1, 0, 1, 9, 2};
    logic [23:0] bfac[5] = '{24'o6, 24'o3, 24'o3, 24'o33333333, 24'o13};
    bit bank, saw_grp, saw_done;
    for (int k = 0; k < 5; k++) begin
      do_reset();
      start_frame("bad_cfg", lens[k], nstgs[k], bfac[k], bank);
      saw_grp = 0;
      saw_done = 0;
      repeat (12) begin
        @(negedge clk);
        if (grp_valid === 1'b1) saw_grp = 1;
        if (frm_done === 1'b1) saw_done = 1;
      end
      vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL bad_cfg%0d err: got %b, required 1", k, err); end
      vectors++; if (busy !== 1'b0 || frm_ready !== 1'b0) begin
        miscompares++; $display("FAIL bad_cfg%0d idle: busy=%b ready=%b, required 0/0", k, busy, frm_ready);
      end
      vectors++; if (saw_grp || saw_done) begin
        miscompares++; $display("FAIL bad_cfg%0d activity: grp=%0b done=%0b, required 0/0", k, saw_grp, saw_done);
      end
      do_reset();
      vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL bad_cfg%0d rst_clr: err=%b, required 0", k, err); end
    end
  endtask

  task automatic test_extra_wb();
    bit bank;
    int n = 0;
    do_reset();
    start_frame("extra_wb", 4, 2, 24'o22, bank);
    while (wb_sent < 2 && n < 100) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    inject_wb = 1;
    n = 0;
    repeat (2) @(negedge clk);
    while (busy !== 1'b0 && n < 300) begin @(negedge clk); n++; end
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL extra_wb err: got %b, required 1", err); end
    vectors++; if (busy !== 1'b0 || frm_ready !== 1'b0) begin
      miscompares++; $display("FAIL extra_wb idle: busy=%b ready=%b, required 0/0", busy, frm_ready);
    end
    do_reset();
  endtask

`ifdef MRD_SCHED_WDOG_EN
  task automatic test_wdog();
    bit bank, saw_done = 0;
    int n = 0;
    do_reset();
    hold_all = 1;
    start_frame("wdog", 12, 1, 24'o3, bank);
    repeat (2) @(negedge clk);
    while (busy !== 1'b0 && n < 100) begin
      if (frm_done === 1'b1) saw_done = 1;
      @(negedge clk);
      n++;
    end
    vectors++; if (err !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL wdog: err=%b busy=%b, required 1/0", err, busy); end
    vectors++; if (saw_done) begin miscompares++; $display("FAIL wdog_done: frm_done seen, required none"); end
    hold_all = 0;
    do_reset();
  endtask
`endif

  task automatic test_reset_mid();
    bit bank;
    int n = 0;
    do_reset();
    hold_stg1 = 1;
    start_frame("mid_rst", 12, 2, 24'o43, bank);
    while (obs.size() < 7 && n < 300) begin @(negedge clk); n++; end
    @(negedge clk);
    vectors++; if (obs.size() != 7 || grp_valid !== 1'b0 || busy !== 1'b1) begin
      miscompares++; $display("FAIL mid_rst drain: groups=%0d valid=%b busy=%b, required 7/0/1", obs.size(), grp_valid, busy);
    end
    hold_stg1 = 0;
    test_reset("mid_rst");
    run_frame("after_rst", 12, 2, 24'o43);
  endtask

  initial begin
    test_reset("por");
    test_basic();
    test_back_to_back();
    test_grp_stall();
    test_bad_cfg();
    test_extra_wb();
`ifdef MRD_SCHED_WDOG_EN
    test_wdog();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
